// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared widths and word type for the fifo_memory read-side drain stage
package fifo_drain_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int COUNT_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: 2-entry ordered register buffer that absorbs the FIFO read latency
module drain_skid_buf
    import fifo_drain_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         clear,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         hd;
    logic         tl;

    assign head_data = mem[hd];

    // tail write, head advance and occupancy; clear empties the buffer and wins over a push
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            hd     <= 1'b0;
            tl     <= 1'b0;
            occ    <= 2'd0;
        end else if (clear) begin
            hd  <= 1'b0;
            tl  <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                mem[tl] <= push_data;
                tl      <= ~tl;
            end
            if (pop) hd <= ~hd;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops fifo_memory and presents its words on a valid/ready stream
module fifo_stream_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = fifo_drain_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = fifo_drain_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    output logic                   m_valid,
    output logic [DATA_WIDTH-1:0]  m_data,
    input  logic                   m_ready,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy
);
    logic       inflight;
    logic       discard;
    logic       pop;
    logic       capture;
    logic [1:0] occ;
    logic [2:0] level;

    // issue a read only if the buffer can still hold it after this cycle's pop
    always_comb begin
        pop              = m_valid && m_ready;
        level            = {1'b0, occ} + {2'b00, inflight};
        capture          = inflight && !discard;
        fifo_read_enable = rstn && !fifo_empty && !flush && (level < (pop ? 3'd3 : 3'd2));
    end

    assign m_valid = occ != 2'd0;
    assign busy    = (occ != 2'd0) || inflight;

    drain_skid_buf #(.W(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (capture),
        .push_data (fifo_read_data),
        .pop       (pop),
        .clear     (flush),
        .head_data (m_data),
        .occ       (occ)
    );

    // read-latency tracking, flush discard marker and delivered-word counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight   <= 1'b0;
            discard    <= 1'b0;
            word_count <= '0;
        end else begin
            inflight   <= fifo_read_enable;
            discard    <= flush && inflight;
            word_count <= word_count + COUNT_WIDTH'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed checks of fifo_stream_drain against a behavioural fifo_memory
module tb_fifo_stream_drain;
    localparam int DW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic [DW-1:0] fifo_read_data = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] word_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fmem [1024];
    int            wr = 0;
    int            rd = 0;
    logic [DW-1:0] got [$];
    int            reads = 0;
    int            bad_rd = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr == rd);

    fifo_stream_drain #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_read_data   (fifo_read_data),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_ready          (m_ready),
        .flush            (flush),
        .word_count       (word_count),
        .busy             (busy)
    );

    // fifo_memory model: registered read, emptied by reset
    always @(posedge clk) begin
        if (!rstn) rd <= wr;
        else if (fifo_read_enable && wr != rd) begin
            fifo_read_data <= fmem[rd % 1024];
            rd <= rd + 1;
        end
    end

    // stream and read-port monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rstn) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (fifo_read_enable) reads++;
            if (fifo_read_enable && fifo_empty) bad_rd++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        if (wr - rd < 1024) begin
            fmem[wr % 1024] = d;
            wr++;
            ok = 1'b1;
        end
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        m_ready = 1'b0;
        flush = 1'b0;
        #1;
        got.delete();
        reads = 0;
        bad_rd = 0;
        tick;
        tick;
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", word_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b want 0", fifo_read_enable); end
    endtask

    task automatic test_stream;
        bit ok;
        do_reset;
        m_ready = 1'b1;
        push(8'h11, ok);
        push(8'h22, ok);
        push(8'h33, ok);
        #1;
        checks++; if (fifo_read_enable !== 1'b1) begin errors++; $display("FAIL stream_issue: got %b want 1", fifo_read_enable); end
        tick;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: got valid %b want 0", m_valid); end
        tick;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("FAIL stream_w0: got %b/%h want 1/11", m_valid, m_data); end
        tick;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h22) begin errors++; $display("FAIL stream_w1: got %b/%h want 1/22", m_valid, m_data); end
        tick;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h33) begin errors++; $display("FAIL stream_w2: got %b/%h want 1/33", m_valid, m_data); end
        tick;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got valid %b want 0", m_valid); end
        checks++; if (word_count !== 32'd3) begin errors++; $display("FAIL stream_count: got %0d want 3", word_count); end
        checks++; if (bad_rd !== 0) begin errors++; $display("FAIL stream_empty_read: got %0d want 0", bad_rd); end
    endtask

    task automatic test_back_pressure;
        logic [DW-1:0] exp [$];
        logic [DW-1:0] first;
        logic [DW-1:0] d;
        bit ok;
        bit stable;
        int n;
        int mism;
        do_reset;
        for (int i = 0; i < 1500; i++) begin
            d = DW'($urandom);
            push(d, ok);
            if (ok) exp.push_back(d);
        end
        repeat (3) tick;
        first = m_data;
        checks++; if (m_valid !== 1'b1 || first !== exp[0]) begin errors++; $display("FAIL bp_head: got %b/%h want 1/%h", m_valid, first, exp[0]); end
        stable = 1'b1;
        repeat (17) begin
            tick;
            if (m_data !== first || m_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable: got %h want %h", m_data, first); end
        checks++; if (reads !== 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", reads); end
        m_ready = 1'b1;
        n = 0;
        while (got.size() < 1024 && n < 1500) begin
            tick;
            n++;
        end
        checks++; if (got.size() !== 1024) begin errors++; $display("FAIL bp_words: got %0d want 1024", got.size()); end
        mism = 0;
        for (int i = 0; i < got.size() && i < 1024; i++) if (got[i] !== exp[i]) mism++;
        checks++; if (mism !== 0) begin errors++; $display("FAIL bp_order: got %0d mismatched words want 0", mism); end
        tick;
        tick;
        checks++; if (word_count !== 32'd1024) begin errors++; $display("FAIL bp_count: got %0d want 1024", word_count); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid %b want 0", m_valid); end
    endtask

    task automatic test_empty_drain;
        bit ok;
        int bad;
        int n;
        int mism;
        do_reset;
        m_ready = 1'b1;
        bad = 0;
        repeat (1500) begin
            tick;
            if (fifo_read_enable !== 1'b0 || m_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL empty_idle: got %0d active cycles want 0", bad); end
        for (int i = 0; i < 100; i++) push(DW'(i * 7 + 3), ok);
        n = 0;
        while (got.size() < 100 && n < 300) begin
            tick;
            n++;
        end
        checks++; if (got.size() !== 100) begin errors++; $display("FAIL empty_words: got %0d want 100", got.size()); end
        mism = 0;
        for (int i = 0; i < got.size() && i < 100; i++) if (got[i] !== DW'(i * 7 + 3)) mism++;
        checks++; if (mism !== 0) begin errors++; $display("FAIL empty_order: got %0d mismatched words want 0", mism); end
        checks++; if (bad_rd !== 0) begin errors++; $display("FAIL empty_read: got %0d want 0", bad_rd); end
    endtask

    task automatic test_toggle_ready;
        logic [DW-1:0] exp [$];
        logic [DW-1:0] d;
        bit ok;
        int n;
        int mism;
        do_reset;
        for (int i = 0; i < 200; i++) begin
            d = DW'($urandom);
            push(d, ok);
            exp.push_back(d);
        end
        n = 0;
        while (got.size() < 200 && n < 2000) begin
            m_ready = ~m_ready;
            tick;
            n++;
        end
        m_ready = 1'b0;
        checks++; if (got.size() !== 200) begin errors++; $display("FAIL toggle_words: got %0d want 200", got.size()); end
        mism = 0;
        for (int i = 0; i < got.size() && i < 200; i++) if (got[i] !== exp[i]) mism++;
        checks++; if (mism !== 0) begin errors++; $display("FAIL toggle_order: got %0d mismatched words want 0", mism); end
        tick;
        checks++; if (word_count !== 32'd200) begin errors++; $display("FAIL toggle_count: got %0d want 200", word_count); end
    endtask

    task automatic test_flush;
        bit ok;
        int n;
        int mism;
        do_reset;
        for (int i = 0; i < 10; i++) push(DW'(8'hA0 + i), ok);
        tick;
        tick;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA0) begin errors++; $display("FAIL flush_pre: got %b/%h want 1/a0", m_valid, m_data); end
        checks++; if (fifo_read_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre_state: got rden %b busy %b want 0 1", fifo_read_enable, busy); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_clear: got valid %b busy %b want 0 0", m_valid, busy); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", word_count); end
        m_ready = 1'b1;
        n = 0;
        while (got.size() < 8 && n < 100) begin
            tick;
            n++;
        end
        repeat (4) tick;
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL flush_words: got %0d want 8", got.size()); end
        mism = 0;
        for (int i = 0; i < got.size() && i < 8; i++) if (got[i] !== DW'(8'hA2 + i)) mism++;
        checks++; if (mism !== 0) begin errors++; $display("FAIL flush_order: got %0d mismatched words want 0", mism); end
        checks++; if (word_count !== 32'd8) begin errors++; $display("FAIL flush_after_count: got %0d want 8", word_count); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset;
        m_ready = 1'b1;
        for (int i = 0; i < 50; i++) push(DW'(i + 1), ok);
        repeat (5) tick;
        checks++; if (m_valid !== 1'b1 || word_count === 32'd0) begin errors++; $display("FAIL mid_pre: got valid %b count %0d want 1 nonzero", m_valid, word_count); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", m_data); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", word_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL mid_rden: got %b want 0", fifo_read_enable); end
        tick;
        tick;
        rstn = 1'b1;
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_back_pressure;
        test_empty_drain;
        test_toggle_ready;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
